// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback,
// registered write outputs, and a pending-write scoreboard for hazard detection.
module regwrite_arbiter #(
    parameter int unsigned WORDSIZE    = 64,
    parameter int unsigned REGADDRSIZE = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic [REGADDRSIZE-1:0] a_rd,
    input  logic [WORDSIZE-1:0]    a_data,
    output logic                   a_ready,
    input  logic                   m_valid,
    input  logic [REGADDRSIZE-1:0] m_rd,
    input  logic [WORDSIZE-1:0]    m_data,
    output logic                   m_ready,
    input  logic                   issue_valid,
    input  logic [REGADDRSIZE-1:0] issue_rd,
    input  logic                   flush,
    input  logic [REGADDRSIZE-1:0] rn,
    input  logic [REGADDRSIZE-1:0] rm,
    output logic                   hazard_n,
    output logic                   hazard_m,
    output logic                   busy,
    output logic                   rf_wren,
    output logic [REGADDRSIZE-1:0] rf_rd,
    output logic [WORDSIZE-1:0]    rf_in
);

    localparam int unsigned           NREGS = 1 << REGADDRSIZE;
    localparam logic [REGADDRSIZE-1:0] XZR  = REGADDRSIZE'(NREGS - 1);

    typedef enum logic {
        PRIO_M = 1'b0,
        PRIO_A = 1'b1
    } prio_t;

    prio_t                  r_prio;
    prio_t                  w_prio_next;
    logic                   w_a_grant;
    logic                   w_m_grant;
    logic                   w_xfer;
    logic [REGADDRSIZE-1:0] w_rd;
    logic [WORDSIZE-1:0]    w_data;
    logic [NREGS-1:0]       r_pending;
    logic [NREGS-1:0]       w_pending_next;
    logic                   r_rf_wren;
    logic [REGADDRSIZE-1:0] r_rf_rd;
    logic [WORDSIZE-1:0]    r_rf_in;

    // Priority pointer register; only moves when both requesters contend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= PRIO_M;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Grant selection and next pointer; nothing is granted while in reset.
    always_comb begin
        w_prio_next = r_prio;
        w_a_grant   = 1'b0;
        w_m_grant   = 1'b0;
        if (reset) begin
            if (a_valid && m_valid) begin
                if (r_prio == PRIO_A) begin
                    w_a_grant   = 1'b1;
                    w_prio_next = PRIO_M;
                end else begin
                    w_m_grant   = 1'b1;
                    w_prio_next = PRIO_A;
                end
            end else begin
                w_a_grant = a_valid;
                w_m_grant = m_valid;
            end
        end
    end

    assign a_ready = w_a_grant;
    assign m_ready = w_m_grant;
    assign w_xfer  = w_a_grant | w_m_grant;
    assign w_rd    = w_a_grant ? a_rd   : m_rd;
    assign w_data  = w_a_grant ? a_data : m_data;

    // Scoreboard update: flush dominates, then a new issue beats a same-edge retire.
    always_comb begin
        w_pending_next = r_pending;
        if (flush) begin
            w_pending_next = '0;
        end else begin
            if (w_xfer) begin
                w_pending_next[w_rd] = 1'b0;
            end
            if (issue_valid && (issue_rd != XZR)) begin
                w_pending_next[issue_rd] = 1'b1;
            end
        end
        w_pending_next[XZR] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Registered write port; XZR writes update address/data but never enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_wren <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_in   <= '0;
        end else if (w_xfer) begin
            r_rf_wren <= (w_rd != XZR);
            r_rf_rd   <= w_rd;
            r_rf_in   <= w_data;
        end else begin
            r_rf_wren <= 1'b0;
        end
    end

    assign rf_wren  = r_rf_wren;
    assign rf_rd    = r_rf_rd;
    assign rf_in    = r_rf_in;
    assign hazard_n = r_pending[rn];
    assign hazard_m = r_pending[rm];
    assign busy     = |r_pending;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural model of arbitration and scoreboard.
module tb_regwrite_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, m_valid, issue_valid, flush;
    logic [4:0]  a_rd, m_rd, issue_rd, rn, rm;
    logic [63:0] a_data, m_data;
    logic        a_ready, m_ready, hazard_n, hazard_m, busy, rf_wren;
    logic [4:0]  rf_rd;
    logic [63:0] rf_in;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Model state: pending set, who is favoured on contention, expected write port.
    bit          mp[32];
    bit          fav_a = 1'b0;
    bit          e_wren = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [63:0] e_in = '0;

    regwrite_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .rn(rn), .rm(rm), .hazard_n(hazard_n), .hazard_m(hazard_m), .busy(busy),
        .rf_wren(rf_wren), .rf_rd(rf_rd), .rf_in(rf_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // 0 = nobody, 1 = ALU, 2 = load
    function automatic int grant();
        if (!reset) return 0;
        if (a_valid && m_valid) return fav_a ? 1 : 2;
        if (a_valid) return 1;
        if (m_valid) return 2;
        return 0;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < 32; i++) if (mp[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mp[i] = 1'b0;
            fav_a  = 1'b0;
            e_wren = 1'b0;
            e_rd   = '0;
            e_in   = '0;
        end else begin
            int g;
            logic [4:0] wrd;
            g = grant();
            if (a_valid && m_valid) fav_a = (g == 2);
            if (g != 0) begin
                wrd    = (g == 1) ? a_rd : m_rd;
                e_wren = (wrd != 5'd31);
                e_rd   = wrd;
                e_in   = (g == 1) ? a_data : m_data;
            end else begin
                wrd    = '0;
                e_wren = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) mp[i] = 1'b0;
            end else begin
                if (g != 0) mp[wrd] = 1'b0;
                if (issue_valid && issue_rd != 5'd31) mp[issue_rd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int g;
            g = grant();
            chk("a_ready",  64'(a_ready),  64'(g == 1));
            chk("m_ready",  64'(m_ready),  64'(g == 2));
            chk("hazard_n", 64'(hazard_n), 64'(mp[rn]));
            chk("hazard_m", 64'(hazard_m), 64'(mp[rm]));
            chk("busy",     64'(busy),     64'(any_pending()));
            chk("rf_wren",  64'(rf_wren),  64'(e_wren));
            chk("rf_rd",    64'(rf_rd),    64'(e_rd));
            chk("rf_in",    rf_in,         e_in);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        reset = 1'b1; a_valid = 0; m_valid = 0; issue_valid = 0; flush = 0;
        a_rd = '0; m_rd = '0; issue_rd = '0; rn = '0; rm = '0;
        a_data = '0; m_data = '0;
        #2 reset = 1'b0;
        a_valid = 1'b1;
        started = 1'b1;
        #2;
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_rf_wren", 64'(rf_wren), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        tick();
        tick();
        reset = 1'b1; a_valid = 1'b0;

        // Single ALU request
        tick();
        a_valid = 1; a_rd = 5; a_data = 64'hAB;
        #1 chk("single_a_ready", 64'(a_ready), 64'd1);
        chk("single_m_ready", 64'(m_ready), 64'd0);
        tick();
        a_valid = 0;
        chk("single_wren", 64'(rf_wren), 64'd1);
        chk("single_rd",   64'(rf_rd),   64'd5);
        chk("single_in",   rf_in,        64'hAB);
        tick();
        chk("single_wren_off", 64'(rf_wren), 64'd0);
        chk("single_rd_hold",  64'(rf_rd),   64'd5);

        // Contention: M, A, M
        a_valid = 1; a_rd = 1; a_data = 64'h11;
        m_valid = 1; m_rd = 2; m_data = 64'h22;
        #1 chk("cont1_m_ready", 64'(m_ready), 64'd1);
        chk("cont1_a_ready", 64'(a_ready), 64'd0);
        tick();
        m_rd = 3; m_data = 64'h33;
        chk("cont1_rd", 64'(rf_rd), 64'd2);
        #1 chk("cont2_a_ready", 64'(a_ready), 64'd1);
        tick();
        a_rd = 4; a_data = 64'h44;
        chk("cont2_wren", 64'(rf_wren), 64'd1);
        chk("cont2_rd",   64'(rf_rd),   64'd1);
        #1 chk("cont3_m_ready", 64'(m_ready), 64'd1);
        tick();
        m_valid = 0;
        chk("cont3_wren", 64'(rf_wren), 64'd1);
        chk("cont3_in",   rf_in,        64'h33);
        #1 chk("cont4_a_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 0;
        chk("cont4_rd", 64'(rf_rd), 64'd4);

        // XZR write does not enable and does not disturb the scoreboard
        issue_valid = 1; issue_rd = 10;
        tick();
        issue_valid = 0;
        chk("xzr_busy_pre", 64'(busy), 64'd1);
        m_valid = 1; m_rd = 31; m_data = 64'h5A;
        #1 chk("xzr_m_ready", 64'(m_ready), 64'd1);
        tick();
        m_valid = 0;
        chk("xzr_wren", 64'(rf_wren), 64'd0);
        chk("xzr_rd",   64'(rf_rd),   64'd31);
        chk("xzr_busy", 64'(busy),    64'd1);

        // Scoreboard set / clear / same-edge / no counting
        rn = 7; rm = 10;
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("sb_haz_n_set", 64'(hazard_n), 64'd1);
        chk("sb_haz_m",     64'(hazard_m), 64'd1);
        a_valid = 1; a_rd = 7; a_data = 64'h77;
        tick();
        a_valid = 0;
        chk("sb_haz_n_clr", 64'(hazard_n), 64'd0);
        issue_valid = 1; issue_rd = 7; a_valid = 1; a_rd = 7; a_data = 64'h78;
        tick();
        issue_valid = 0; a_valid = 0;
        chk("sb_same_edge", 64'(hazard_n), 64'd1);
        chk("sb_same_wren", 64'(rf_wren),  64'd1);
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        a_valid = 1; a_rd = 7;
        tick();
        a_valid = 0;
        chk("sb_no_count", 64'(hazard_n), 64'd0);

        // Flush with a concurrent issue and in-flight requests
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_rd = 9;
        tick();
        issue_valid = 0;
        chk("fl_busy_pre", 64'(busy), 64'd1);
        flush = 1; issue_valid = 1; issue_rd = 4;
        a_valid = 1; a_rd = 3; a_data = 64'h333;
        m_valid = 1; m_rd = 9; m_data = 64'h999;
        tick();
        flush = 0; issue_valid = 0; a_valid = 0;
        chk("fl_busy",  64'(busy),   64'd0);
        chk("fl_wr_rd", 64'(rf_rd),  64'd3);
        chk("fl_wr_in", rf_in,       64'h333);
        #1 chk("fl_m_ready", 64'(m_ready), 64'd1);
        tick();
        m_valid = 0;
        chk("fl_m_written", 64'(rf_rd), 64'd9);

        // Asynchronous reset mid-cycle with a request held
        issue_valid = 1; issue_rd = 6;
        tick();
        issue_valid = 0;
        a_valid = 1; a_rd = 12; a_data = 64'hC0FFEE;
        #2 reset = 0;
        #1;
        chk("arst_wren",    64'(rf_wren), 64'd0);
        chk("arst_rd",      64'(rf_rd),   64'd0);
        chk("arst_in",      rf_in,        64'd0);
        chk("arst_busy",    64'(busy),    64'd0);
        chk("arst_a_ready", 64'(a_ready), 64'd0);
        tick();
        reset = 1;
        #1 chk("post_rst_a_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 0;
        chk("post_rst_wren", 64'(rf_wren), 64'd1);
        chk("post_rst_rd",   64'(rf_rd),   64'd12);

        // Mixed traffic obeying the hold-until-accepted rule
        for (int i = 0; i < 80; i++) begin
            logic [4:0] r;
            if (!a_valid && $urandom_range(0, 1) == 1) begin
                r = 5'($urandom_range(0, 8));
                a_valid = 1; a_rd = (r == 5'd8) ? 5'd31 : r; a_data = {$urandom, $urandom};
            end
            if (!m_valid && $urandom_range(0, 1) == 1) begin
                r = 5'($urandom_range(0, 8));
                m_valid = 1; m_rd = (r == 5'd8) ? 5'd31 : r; m_data = {$urandom, $urandom};
            end
            r = 5'($urandom_range(0, 8));
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd = (r == 5'd8) ? 5'd31 : r;
            flush = ($urandom_range(0, 15) == 0);
            rn = 5'($urandom_range(0, 8));
            rm = 5'($urandom_range(0, 8));
            #1 g = grant();
            tick();
            if (g == 1) a_valid = 0;
            if (g == 2) m_valid = 0;
        end
        a_valid = 0; m_valid = 0; issue_valid = 0; flush = 0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
